// File: rtl/hack_data_memory.sv
// hack_data_memory: Hack CPU data memory with RAM, dual-port screen, keyboard register and sticky bus-error trap
module hack_data_memory #(
  parameter int RAM_DEPTH = 16384,
  parameter int SCREEN_BASE = 16384,
  parameter int SCREEN_DEPTH = 8192,
  parameter int KBD_ADDR = 24576
) (
  input  logic                            i_CLK,
  input  logic                            i_RESET,
  input  logic [15:0]                     i_Address,
  input  logic [15:0]                     i_Data,
  input  logic                            i_Write,
  output logic [15:0]                     o_Data,
  input  logic                            i_Key_Valid,
  input  logic [15:0]                     i_Key_Code,
  input  logic                            i_Key_Release,
  input  logic [$clog2(SCREEN_DEPTH)-1:0] i_Vid_Address,
  output logic [15:0]                     o_Vid_Data,
  output logic                            o_Bus_Error,
  output logic [15:0]                     o_Error_Address
);
  localparam int RW = $clog2(RAM_DEPTH);
  localparam int VW = $clog2(SCREEN_DEPTH);
  logic [15:0] ram [RAM_DEPTH];
  logic [15:0] screen [SCREEN_DEPTH];
  logic [15:0] kbd;
  logic is_ram, is_scr, is_kbd, wr;
  logic [RW-1:0] ram_idx;
  logic [VW-1:0] scr_idx;
  always_comb begin
    is_ram = 32'(i_Address) < RAM_DEPTH;
    is_scr = 32'(i_Address) >= SCREEN_BASE && 32'(i_Address) < SCREEN_BASE + SCREEN_DEPTH;
    is_kbd = 32'(i_Address) == KBD_ADDR;
    ram_idx = RW'(i_Address);
    scr_idx = VW'(i_Address - 16'(SCREEN_BASE));
    wr = i_Write && !i_RESET;
    o_Data = is_ram ? ram[ram_idx] : is_scr ? screen[scr_idx] : is_kbd ? kbd : 16'h0000;
  end
  always_ff @(posedge i_CLK) begin
    if (wr && is_ram) ram[ram_idx] <= i_Data;
    if (wr && is_scr) screen[scr_idx] <= i_Data;
  end
  // Video read samples the pre-write word, so a colliding CPU write is seen one frame later.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      o_Vid_Data <= 16'h0000;
      kbd <= 16'h0000;
      o_Bus_Error <= 1'b0;
      o_Error_Address <= 16'h0000;
    end else begin
      o_Vid_Data <= screen[i_Vid_Address];
      kbd <= i_Key_Valid ? i_Key_Code : i_Key_Release ? 16'h0000 : kbd;
      if (i_Write && !is_ram && !is_scr && !o_Bus_Error) begin
        o_Bus_Error <= 1'b1;
        o_Error_Address <= i_Address;
      end
    end
  end
endmodule
